// File: rtl/huffman_pkg.sv
// rtl/huffman_pkg.sv - shared defaults and FSM encoding for the Huffman code-length stage
package huffman_pkg;

  localparam int HUFF_SYMBOLS      = 16;
  localparam int HUFF_FREQ_WIDTH   = 32;
  localparam int HUFF_SYMBOL_WIDTH = 5;
  localparam int HUFF_LEN_WIDTH    = $clog2(HUFF_SYMBOLS);
  localparam int HUFF_WEIGHT_WIDTH = HUFF_FREQ_WIDTH + $clog2(HUFF_SYMBOLS);

  typedef enum logic [2:0] {
    IDLE,
    MERGE_A,
    MERGE_B,
    DEPTH_INT,
    DEPTH_LEAF,
    DONE
  } state_t;

endpackage

// File: rtl/huffman_code_length_gen_min_select.sv
// rtl/huffman_code_length_gen_min_select.sv - two-queue head comparison (huff_min_select)
// Ties go to the leaf queue so equal weights keep the tree shallow on the leaf side.
module huff_min_select
  import huffman_pkg::*;
#(
  parameter int WEIGHT_WIDTH = HUFF_WEIGHT_WIDTH
) (
  input  logic                    leaf_valid,
  input  logic [WEIGHT_WIDTH-1:0] leaf_weight,
  input  logic                    int_valid,
  input  logic [WEIGHT_WIDTH-1:0] int_weight,
  output logic                    pick_leaf,
  output logic [WEIGHT_WIDTH-1:0] pick_weight
);

  assign pick_leaf   = leaf_valid && (!int_valid || (leaf_weight <= int_weight));
  assign pick_weight = pick_leaf ? leaf_weight : int_weight;

endmodule

// File: rtl/huffman_code_length_gen.sv
// rtl/huffman_code_length_gen.sv - two-queue Huffman tree build and per-symbol code lengths
// Optional length-limit flag: HUFF_LEN_OVERFLOW_CHECK_EN.
module huffman_code_length_gen
  import huffman_pkg::*;
#(
  parameter int SYMBOLS      = HUFF_SYMBOLS,
  parameter int FREQ_WIDTH   = HUFF_FREQ_WIDTH,
  parameter int SYMBOL_WIDTH = HUFF_SYMBOL_WIDTH,
  parameter int LEN_WIDTH    = $clog2(SYMBOLS),
  parameter int WEIGHT_WIDTH = FREQ_WIDTH + $clog2(SYMBOLS),
  parameter int MAX_CODE_LEN = 15
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [SYMBOLS*FREQ_WIDTH-1:0]   sorted_frequencies_flat,
  input  logic [SYMBOLS*SYMBOL_WIDTH-1:0] sorted_symbol_flat,
  output logic                            busy,
  output logic [SYMBOLS*LEN_WIDTH-1:0]    code_len_flat,
  output logic                            code_len_valid,
  output logic                            len_overflow
);

  localparam int IDX_W  = $clog2(SYMBOLS + 1);
  localparam int SIDX_W = $clog2(SYMBOLS);
  typedef logic [IDX_W-1:0] idx_t;

  state_t state, state_next;

  logic [FREQ_WIDTH-1:0]   freq_q      [SYMBOLS];
  logic [SYMBOL_WIDTH-1:0] sym_q       [SYMBOLS];
  logic [WEIGHT_WIDTH-1:0] int_weight  [SYMBOLS];
  logic [SIDX_W-1:0]       leaf_parent [SYMBOLS];
  logic [SIDX_W-1:0]       int_parent  [SYMBOLS];
  logic [LEN_WIDTH-1:0]    int_depth   [SYMBOLS];
  logic [LEN_WIDTH-1:0]    code_len    [SYMBOLS];

  idx_t l0_q, n_q, lp, ih, k, j, i_q;
  idx_t l0_in, n_in, last_node;

  logic                    pa_leaf;
  logic [SIDX_W-1:0]       pa_idx;
  logic [WEIGHT_WIDTH-1:0] pa_weight;

  logic                    leaf_avail, int_avail, pick_leaf;
  logic [WEIGHT_WIDTH-1:0] leaf_w, int_w, pick_w;
  logic [SIDX_W-1:0]       lp_s, ih_s, k_s, j_s, i_s;
  logic [LEN_WIDTH-1:0]    node_depth, leaf_len;

  // Inputs are ascending, so the first nonzero slot bounds the active leaves.
  always_comb begin
    l0_in = idx_t'(SYMBOLS);
    for (int s = SYMBOLS - 1; s >= 0; s--) begin
      if (sorted_frequencies_flat[s*FREQ_WIDTH +: FREQ_WIDTH] != '0) l0_in = idx_t'(s);
    end
    n_in = idx_t'(SYMBOLS) - l0_in;
  end

  assign last_node  = n_q - idx_t'(2);
  assign lp_s       = lp[SIDX_W-1:0];
  assign ih_s       = ih[SIDX_W-1:0];
  assign k_s        = k[SIDX_W-1:0];
  assign j_s        = j[SIDX_W-1:0];
  assign i_s        = i_q[SIDX_W-1:0];
  assign leaf_avail = lp < idx_t'(SYMBOLS);
  assign int_avail  = ih < k;
  assign leaf_w     = WEIGHT_WIDTH'(freq_q[lp_s]);
  assign int_w      = int_weight[ih_s];

  huff_min_select #(
    .WEIGHT_WIDTH(WEIGHT_WIDTH)
  ) u_min_select (
    .leaf_valid (leaf_avail),
    .leaf_weight(leaf_w),
    .int_valid  (int_avail),
    .int_weight (int_w),
    .pick_leaf  (pick_leaf),
    .pick_weight(pick_w)
  );

  // Parents always carry a higher index, so a top-down sweep sees them first.
  assign node_depth = (j == last_node) ? '0 : int_depth[int_parent[j_s]] + LEN_WIDTH'(1);

  always_comb begin
    leaf_len = '0;
    if (i_q < l0_q)               leaf_len = '0;
    else if (n_q == idx_t'(1))    leaf_len = LEN_WIDTH'(1);
    else                          leaf_len = int_depth[leaf_parent[i_s]] + LEN_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:       if (start) state_next = (n_in >= idx_t'(2)) ? MERGE_A : DEPTH_LEAF;
      MERGE_A:    state_next = MERGE_B;
      MERGE_B:    state_next = (k == last_node) ? DEPTH_INT : MERGE_A;
      DEPTH_INT:  if (j == '0) state_next = DEPTH_LEAF;
      DEPTH_LEAF: if (i_q == idx_t'(SYMBOLS - 1)) state_next = DONE;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYMBOLS; s++) begin
        freq_q[s]      <= '0;
        sym_q[s]       <= '0;
        int_weight[s]  <= '0;
        leaf_parent[s] <= '0;
        int_parent[s]  <= '0;
        int_depth[s]   <= '0;
        code_len[s]    <= '0;
      end
      l0_q           <= '0;
      n_q            <= '0;
      lp             <= '0;
      ih             <= '0;
      k              <= '0;
      j              <= '0;
      i_q            <= '0;
      pa_leaf        <= 1'b0;
      pa_idx         <= '0;
      pa_weight      <= '0;
      busy           <= 1'b0;
      code_len_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          for (int s = 0; s < SYMBOLS; s++) begin
            freq_q[s]   <= sorted_frequencies_flat[s*FREQ_WIDTH +: FREQ_WIDTH];
            sym_q[s]    <= sorted_symbol_flat[s*SYMBOL_WIDTH +: SYMBOL_WIDTH];
            code_len[s] <= '0;
          end
          l0_q           <= l0_in;
          n_q            <= n_in;
          lp             <= l0_in;
          ih             <= '0;
          k              <= '0;
          j              <= '0;
          i_q            <= '0;
          busy           <= 1'b1;
          code_len_valid <= 1'b0;
        end
        MERGE_A: begin
          pa_leaf   <= pick_leaf;
          pa_weight <= pick_w;
          if (pick_leaf) begin
            pa_idx <= lp_s;
            lp     <= lp + idx_t'(1);
          end else begin
            pa_idx <= ih_s;
            ih     <= ih + idx_t'(1);
          end
        end
        MERGE_B: begin
          int_weight[k_s] <= pa_weight + pick_w;
          if (pa_leaf) leaf_parent[pa_idx] <= k_s;
          else         int_parent[pa_idx]  <= k_s;
          if (pick_leaf) begin
            leaf_parent[lp_s] <= k_s;
            lp                <= lp + idx_t'(1);
          end else begin
            int_parent[ih_s] <= k_s;
            ih               <= ih + idx_t'(1);
          end
          k <= k + idx_t'(1);
          j <= k;
        end
        DEPTH_INT: begin
          int_depth[j_s] <= node_depth;
          j              <= j - idx_t'(1);
        end
        DEPTH_LEAF: begin
          for (int s = 0; s < SYMBOLS; s++) begin
            if (sym_q[i_s] == SYMBOL_WIDTH'(s)) code_len[s] <= leaf_len;
          end
          i_q <= i_q + idx_t'(1);
        end
        DONE: begin
          busy           <= 1'b0;
          code_len_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < SYMBOLS; g++) begin : g_pack
    assign code_len_flat[g*LEN_WIDTH +: LEN_WIDTH] = code_len[g];
  end

`ifdef HUFF_LEN_OVERFLOW_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   len_overflow <= 1'b0;
    else if (state == IDLE && start)             len_overflow <= 1'b0;
    else if (state == DEPTH_LEAF &&
             32'(leaf_len) > MAX_CODE_LEN)       len_overflow <= 1'b1;
  end
`else
  assign len_overflow = 1'b0;
`endif

endmodule
